fpga_cfg_loader: RTL

//  Configuration controller for the FPGA fabric. Receives a serial bitstream from two slow
//  pin inputs and hunts for a sync word. Streams CHAIN_LEN config bits into the fabric

---
 rtl/fpga_cfg_loader_if.sv | 16 +
 rtl/fpga_cfg_loader.sv | 103 ++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader_if.sv
// fpga_cfg_loader_if: serial config pins in, fabric chain and status out
interface fpga_cfg_loader_if;
  logic cfg_sclk_i;
  logic cfg_sdata_i;
  logic cfg_restart_i;
  logic chain_shift_o;
  logic chain_data_o;
  logic fabric_en_o;
  logic cfg_busy_o;
  logic cfg_done_o;
  logic cfg_err_o;
  modport master(output cfg_sclk_i, cfg_sdata_i, cfg_restart_i,
                 input chain_shift_o, chain_data_o, fabric_en_o, cfg_busy_o, cfg_done_o, cfg_err_o);
  modport slave(input cfg_sclk_i, cfg_sdata_i, cfg_restart_i,
                output chain_shift_o, chain_data_o, fabric_en_o, cfg_busy_o, cfg_done_o, cfg_err_o);
endinterface

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: sync-word hunt, config chain load and CRC-8 check of a pin-driven bitstream
module fpga_cfg_loader #(
  parameter int         CHAIN_LEN = 64,
  parameter logic [7:0] SYNC_WORD = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  fpga_cfg_loader_if.slave cfg
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  typedef enum logic [2:0] {HUNT, LOAD, CHECK, DONE, ERROR} state_t;
  state_t state_q;
  logic [2:0] sclk_q;
  logic [1:0] sdata_q;
  logic ev_q, bit_q;
  logic [7:0] win_q, crc_q, win_d, crc_d;
  logic [CW-1:0] cnt_q;
  logic [2:0] ccnt_q;
  logic shift_q, data_q, en_q, busy_q, done_q, err_q;
  logic fb;
  assign win_d = {win_q[6:0], bit_q};
  assign fb    = bit_q ^ crc_q[7];
  assign crc_d = {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  // sclk/sdata: two sync flops, an edge-detect flop, then the event is registered with its bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sclk_q  <= '0;
      sdata_q <= '0;
      ev_q    <= 1'b0;
      bit_q   <= 1'b0;
      win_q   <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      ccnt_q  <= '0;
      shift_q <= 1'b0;
      data_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], cfg.cfg_sclk_i};
      sdata_q <= {sdata_q[0], cfg.cfg_sdata_i};
      ev_q    <= sclk_q[1] & ~sclk_q[2];
      bit_q   <= sdata_q[1];
      shift_q <= 1'b0;
      if (cfg.cfg_restart_i) begin
        state_q <= HUNT;
        win_q   <= '0;
        crc_q   <= '0;
        cnt_q   <= '0;
        ccnt_q  <= '0;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
      end else if (ev_q) begin
        case (state_q)
          HUNT: begin
            win_q <= win_d;
            if (win_d == SYNC_WORD) begin
              state_q <= LOAD;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              crc_q   <= '0;
            end
          end
          LOAD: begin
            shift_q <= 1'b1;
            data_q  <= bit_q;
            crc_q   <= crc_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_q <= CHECK;
              ccnt_q  <= '0;
              win_q   <= '0;
            end
          end
          CHECK: begin
            win_q  <= win_d;
            ccnt_q <= ccnt_q + 3'd1;
            if (ccnt_q == 3'd7) begin
              state_q <= (win_d == crc_q) ? DONE : ERROR;
              busy_q  <= 1'b0;
              done_q  <= win_d == crc_q;
              en_q    <= win_d == crc_q;
              err_q   <= win_d != crc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign cfg.chain_shift_o = shift_q;
  assign cfg.chain_data_o  = data_q;
  assign cfg.fabric_en_o   = en_q;
  assign cfg.cfg_busy_o    = busy_q;
  assign cfg.cfg_done_o    = done_q;
  assign cfg.cfg_err_o     = err_q;
endmodule
